// File: rtl/dma_seq_pkg.sv
// rtl/dma_seq_pkg.sv - state encoding and defaults shared by the DMA transfer sequencer
package dma_seq_pkg;

  localparam int PAGE_BITS_DEF = 8;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0000,
    ST_SETUP    = 4'b0001,
    ST_READ     = 4'b0010,
    ST_MODIFY   = 4'b0011,
    ST_WRITE    = 4'b0100,
    ST_PAGE     = 4'b0101,
    ST_NEXT_ROW = 4'b0110,
    ST_DONE     = 4'b0111
  } dma_state_e;

endpackage

// File: rtl/dma_addr_gen.sv
// rtl/dma_addr_gen.sv - 2-D address walker: x/y counters, element/row stepping, page-carry flag
module dma_addr_gen #(
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = 8,
  parameter int PAGE_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              elem_done,
  input  logic              row_done,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [CNT_W-1:0]  x_count,
  input  logic [CNT_W-1:0]  y_count,
  input  logic              xskip,
  input  logic              yskip,
  output logic [ADDR_W-1:0] addr,
  output logic              x_last,
  output logic              y_last,
  output logic              page_carry
);

  logic [ADDR_W-1:0]  row_addr;
  logic [ADDR_W-1:0]  x_step;
  logic [ADDR_W-1:0]  row_step;
  logic [ADDR_W-1:0]  next_addr;
  logic [ADDR_W-1:0]  next_row;
  logic [CNT_W-1:0]   x_cnt;
  logic [CNT_W-1:0]   y_cnt;
  logic [PAGE_BITS:0] low_sum;

  assign x_step    = xskip ? ADDR_W'(2) : ADDR_W'(1);
  assign row_step  = yskip ? (row_stride << 1) : row_stride;
  assign next_addr = addr + x_step;
  assign next_row  = row_addr + row_step;

  // Carry out of the in-page offset bits marks a page crossing for the next element.
  assign low_sum    = {1'b0, addr[PAGE_BITS-1:0]} + {{(PAGE_BITS-1){1'b0}}, xskip, ~xskip};
  assign page_carry = low_sum[PAGE_BITS];

  assign x_last = (x_cnt == CNT_W'(1));
  assign y_last = (y_cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      row_addr <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
    end else if (load) begin
      addr     <= base_addr;
      row_addr <= base_addr;
      x_cnt    <= x_count;
      y_cnt    <= y_count;
    end else if (elem_done) begin
      x_cnt <= x_cnt - CNT_W'(1);
      if (!x_last) begin
        addr <= next_addr;
      end
    end else if (row_done) begin
      y_cnt <= y_cnt - CNT_W'(1);
      if (!y_last) begin
        row_addr <= next_row;
        addr     <= next_row;
        x_cnt    <= x_count;
      end
    end
  end

endmodule

// File: rtl/dma_xfer_sequencer.sv
// rtl/dma_xfer_sequencer.sv - DMA present-state FSM sequencing 2-D block transfers onto the memory port
module dma_xfer_sequencer
  import dma_seq_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = 8,
  parameter int PAGE_BITS = PAGE_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  x_count,
  input  logic [CNT_W-1:0]  y_count,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic              xskip,
  input  logic              yskip,
  input  logic              page,
  input  logic              rmwb,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic [3:0]        dmpst,
  output logic              busy,
  output logic              done
);

  dma_state_e state, next_state, elem_next;

  logic [ADDR_W-1:0] cfg_base;
  logic [ADDR_W-1:0] cfg_stride;
  logic [CNT_W-1:0]  cfg_x;
  logic [CNT_W-1:0]  cfg_y;
  logic              cfg_xskip;
  logic              cfg_yskip;
  logic              cfg_page;
  logic              cfg_rmwb;

  logic              load;
  logic              elem_done;
  logic              row_done;
  logic              x_last;
  logic              y_last;
  logic              page_carry;
  logic [ADDR_W-1:0] addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_base   <= '0;
      cfg_stride <= '0;
      cfg_x      <= '0;
      cfg_y      <= '0;
      cfg_xskip  <= 1'b0;
      cfg_yskip  <= 1'b0;
      cfg_page   <= 1'b0;
      cfg_rmwb   <= 1'b1;
    end else if (state == ST_IDLE && start) begin
      cfg_base   <= base_addr;
      cfg_stride <= row_stride;
      cfg_x      <= x_count;
      cfg_y      <= y_count;
      cfg_xskip  <= xskip;
      cfg_yskip  <= yskip;
      cfg_page   <= page;
      cfg_rmwb   <= rmwb;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    elem_done  = 1'b0;
    row_done   = 1'b0;
    // Where a completed element leads: end of row, page stall, or the next read.
    if (x_last) begin
      elem_next = ST_NEXT_ROW;
    end else if (cfg_page && page_carry) begin
      elem_next = ST_PAGE;
    end else begin
      elem_next = ST_READ;
    end
    case (state)
      ST_IDLE:     if (start) next_state = ST_SETUP;
      ST_SETUP: begin
        if (cfg_x == '0 || cfg_y == '0) begin
          next_state = ST_DONE;
        end else begin
          load       = 1'b1;
          next_state = ST_READ;
        end
      end
      ST_READ: begin
        if (mem_ack) begin
          if (!cfg_rmwb) begin
            next_state = ST_MODIFY;
          end else begin
            elem_done  = 1'b1;
            next_state = elem_next;
          end
        end
      end
      ST_MODIFY:   next_state = ST_WRITE;
      ST_WRITE: begin
        if (mem_ack) begin
          elem_done  = 1'b1;
          next_state = elem_next;
        end
      end
      ST_PAGE:     next_state = ST_READ;
      ST_NEXT_ROW: begin
        row_done   = 1'b1;
        next_state = y_last ? ST_DONE : ST_READ;
      end
      ST_DONE:     next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) begin
      next_state = ST_IDLE;
      load       = 1'b0;
      elem_done  = 1'b0;
      row_done   = 1'b0;
    end
  end

  dma_addr_gen #(
    .ADDR_W    (ADDR_W),
    .CNT_W     (CNT_W),
    .PAGE_BITS (PAGE_BITS)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .elem_done  (elem_done),
    .row_done   (row_done),
    .base_addr  (cfg_base),
    .row_stride (cfg_stride),
    .x_count    (cfg_x),
    .y_count    (cfg_y),
    .xskip      (cfg_xskip),
    .yskip      (cfg_yskip),
    .addr       (addr),
    .x_last     (x_last),
    .y_last     (y_last),
    .page_carry (page_carry)
  );

  // Port outputs decode from the state register only, so reset clears them asynchronously.
  assign mem_req  = (state == ST_READ) || (state == ST_WRITE);
  assign mem_we   = (state == ST_WRITE);
  assign mem_addr = addr;
  assign dmpst    = state;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

endmodule
